iter_divider: RTL and testbench

- Parametrised, multi-cycle unsigned integer divider built from restoring shift/compare/subtract steps.
- Performs STEPS_PER_CYCLE quotient-bit steps per clock, so throughput and area are selectable.
- Uses valid/ready handshakes on input and output and detects divide-by-zero.
- Sits between the operand issue logic and the result writeback in the arithmetic datapath.

---
 rtl/iter_divider.sv | 129 ++++++++++++
 tb/tb_iter_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle unsigned restoring divider, STEPS_PER_CYCLE quotient bits per clock.
// Valid/ready on both sides; a zero divisor yields all-ones quotient and flags div_by_zero.
module iter_divider #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int ITERS = WIDTH / STEPS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] divr;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             dbz;
    logic             accept;

    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH:0]   trial;

    assign accept      = in_valid && in_ready;
    assign quotient    = quo;
    assign remainder   = rem;
    assign div_by_zero = dbz;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (count == CW'(1)) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Trial compare is WIDTH+1 bits wide; when it succeeds the difference
    // is below the divisor, so a WIDTH-bit subtract gives the exact result.
    always_comb begin
        shreg_next = shreg;
        rem_next   = rem;
        quo_next   = quo;
        trial      = '0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            trial      = {rem_next, shreg_next[WIDTH-1]};
            shreg_next = {shreg_next[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, divr}) begin
                rem_next = trial[WIDTH-1:0] - divr;
                quo_next = {quo_next[WIDTH-2:0], 1'b1};
            end else begin
                rem_next = trial[WIDTH-1:0];
                quo_next = {quo_next[WIDTH-2:0], 1'b0};
            end
        end
    end

    // A zero divisor preloads the saturated result and spends a single
    // RUN cycle holding it, so its result appears one edge after accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            divr  <= '0;
            quo   <= '0;
            rem   <= '0;
            count <= '0;
            dbz   <= 1'b0;
        end else if (accept) begin
            divr <= divisor;
            if (divisor == '0) begin
                dbz   <= 1'b1;
                count <= CW'(1);
                shreg <= '0;
                quo   <= '1;
                rem   <= dividend;
            end else begin
                dbz   <= 1'b0;
                count <= CW'(ITERS);
                shreg <= dividend;
                quo   <= '0;
                rem   <= '0;
            end
        end else if (state == RUN) begin
            count <= count - CW'(1);
            if (!dbz) begin
                shreg <= shreg_next;
                rem   <= rem_next;
                quo   <= quo_next;
            end
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: a 32-bit single-step instance and a
// 16-bit four-step instance, checked against hand-computed results.
module tb_iter_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        out_ready;

    logic        in_valid, in_ready, out_valid, div_by_zero, busy;
    logic [31:0] dividend, divisor, quotient, remainder;

    logic        in_valid16, in_ready16, out_valid16, div_by_zero16, busy16;
    logic [15:0] dividend16, divisor16, quotient16, remainder16;

    int checks   = 0;
    int failures = 0;

    iter_divider #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    iter_divider #(.WIDTH(16), .STEPS_PER_CYCLE(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .dividend(dividend16), .divisor(divisor16), .out_valid(out_valid16),
        .out_ready(out_ready), .quotient(quotient16), .remainder(remainder16),
        .div_by_zero(div_by_zero16), .busy(busy16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Operands are scrambled right after the accept edge to prove they were latched.
    task automatic applyStimulus(input logic sel16, input logic [31:0] a, input logic [31:0] b);
        int n;
        if (sel16) begin
            in_valid16 = 1'b1; dividend16 = a[15:0]; divisor16 = b[15:0];
        end else begin
            in_valid = 1'b1; dividend = a; divisor = b;
        end
        n = 0;
        while (!(sel16 ? in_ready16 : in_ready) && n < 200) begin
            tick();
            n++;
        end
        checkFlag("in_ready_before_accept", sel16 ? in_ready16 : in_ready, 1'b1);
        tick();
        if (sel16) begin
            in_valid16 = 1'b0; dividend16 = ~a[15:0]; divisor16 = b[15:0] ^ 16'h5A5A;
        end else begin
            in_valid = 1'b0; dividend = ~a; divisor = b ^ 32'h5A5A_5A5A;
        end
    endtask

    task automatic waitResult(input logic sel16, input int latency);
        int n;
        n = 0;
        while (!(sel16 ? out_valid16 : out_valid) && n < 100) begin
            tick();
            n++;
        end
        checkOutput("latency", 32'(n), 32'(latency));
    endtask

    task automatic finishOp(input logic sel16, input logic [31:0] q, input logic [31:0] r, input logic z);
        checkOutput("quotient", sel16 ? 32'(quotient16) : quotient, q);
        checkOutput("remainder", sel16 ? 32'(remainder16) : remainder, r);
        checkFlag("div_by_zero", sel16 ? div_by_zero16 : div_by_zero, z);
        checkFlag("in_ready_in_done", sel16 ? in_ready16 : in_ready, 1'b0);
        tick();
        checkFlag("out_valid_after_release", sel16 ? out_valid16 : out_valid, 1'b0);
        checkFlag("in_ready_after_release", sel16 ? in_ready16 : in_ready, 1'b1);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] a16, b16;
        rst_n = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; dividend = '0; divisor = '0;
        in_valid16 = 1'b0; dividend16 = '0; divisor16 = '0;
        repeat (3) tick();
        checkFlag("reset_out_valid", out_valid, 1'b0);
        checkFlag("reset_busy", busy, 1'b0);
        checkFlag("reset_dbz", div_by_zero, 1'b0);
        checkOutput("reset_quotient", quotient, 32'h0);
        checkOutput("reset_remainder", remainder, 32'h0);
        rst_n = 1'b1;
        tick();
        checkFlag("reset_in_ready", in_ready, 1'b1);

        $display("[TB] basic 100/7");
        applyStimulus(1'b0, 32'd100, 32'd7);
        waitResult(1'b0, 32);
        checkFlag("busy_in_done", busy, 1'b1);
        finishOp(1'b0, 32'd14, 32'd2, 1'b0);

        $display("[TB] wide remainder cases");
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
        waitResult(1'b0, 32);
        finishOp(1'b0, 32'd1, 32'h7FFF_FFFF, 1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
        waitResult(1'b0, 32);
        finishOp(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);

        $display("[TB] divide by zero");
        applyStimulus(1'b0, 32'h1234, 32'd0);
        waitResult(1'b0, 1);
        finishOp(1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        applyStimulus(1'b0, 32'd1000, 32'd10);
        waitResult(1'b0, 32);
        finishOp(1'b0, 32'd100, 32'd0, 1'b0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(1'b0, 32'd50, 32'd5);
        waitResult(1'b0, 32);
        in_valid = 1'b1; dividend = 32'd77; divisor = 32'd7;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkFlag("bp_out_valid", out_valid, 1'b1);
            checkFlag("bp_in_ready", in_ready, 1'b0);
            checkOutput("bp_quotient", quotient, 32'd10);
            checkOutput("bp_remainder", remainder, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        checkFlag("bp_release_valid", out_valid, 1'b0);
        checkFlag("bp_release_ready", in_ready, 1'b1);
        applyStimulus(1'b0, 32'd77, 32'd7);
        waitResult(1'b0, 32);
        finishOp(1'b0, 32'd11, 32'd0, 1'b0);

        $display("[TB] reset during run");
        applyStimulus(1'b0, 32'hDEAD, 32'd3);
        repeat (10) tick();
        checkFlag("run_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        checkFlag("midreset_out_valid", out_valid, 1'b0);
        checkFlag("midreset_busy", busy, 1'b0);
        checkFlag("midreset_in_ready", in_ready, 1'b1);
        checkOutput("midreset_quotient", quotient, 32'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, 32'd9, 32'd3);
        waitResult(1'b0, 32);
        finishOp(1'b0, 32'd3, 32'd0, 1'b0);

        $display("[TB] 16-bit, 4 steps per cycle");
        for (int i = 0; i < 1000; i++) begin
            case (i % 8)
                0:       begin a16 = 16'h0000;            b16 = 16'($urandom_range(1, 65535)); end
                1:       begin a16 = 16'hFFFF;            b16 = 16'h0001; end
                2:       begin a16 = 16'($urandom);       b16 = 16'h0000; end
                3:       begin a16 = 16'hFFFF;            b16 = 16'hFFFF; end
                4:       begin a16 = 16'h0001;            b16 = 16'hFFFF; end
                5:       begin a16 = 16'($urandom);       b16 = 16'h8000; end
                default: begin a16 = 16'($urandom);       b16 = 16'($urandom_range(1, 300)); end
            endcase
            applyStimulus(1'b1, 32'(a16), 32'(b16));
            if (b16 == 16'h0000) begin
                waitResult(1'b1, 1);
                finishOp(1'b1, 32'h0000_FFFF, 32'(a16), 1'b1);
            end else begin
                waitResult(1'b1, 4);
                checkFlag("rem_below_divisor", remainder16 < b16, 1'b1);
                finishOp(1'b1, 32'(a16 / b16), 32'(a16 % b16), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
